// File: rtl/mem_port_arbiter_if.sv
// Memory-port arbiter bus bundle.
// Fetch/load-store requesters plus the shared memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_grant;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_grant;
  logic              data_valid;
  logic [DATA_W-1:0] data_rdata;
  logic              data_misaligned;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  inst_req, inst_addr,
    output inst_grant, inst_valid, inst_rdata,
    input  data_req, data_we, data_addr, data_wdata,
    output data_grant, data_valid, data_rdata,
    output data_misaligned,
    output mem_addr, mem_wdata, mem_wr,
    input  mem_rdata,
    output busy
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_grant, inst_valid, inst_rdata,
    output data_req, data_we, data_addr, data_wdata,
    input  data_grant, data_valid, data_rdata,
    input  data_misaligned,
    input  mem_addr, mem_wdata, mem_wr,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin fetch / load-store arbiter for one memory port.
// Sequences each access over a fixed read latency.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int MEM_LATENCY = 2
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic pick_data;
  logic inst_grant;
  logic data_grant;
  logic in_busy;
  logic in_resp;

  // owner/rr_last encoding: 0 = fetch, 1 = load/store
  // Next-state, access latching and combinational grants
  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    pick_data    = 1'b0;
    inst_grant   = 1'b0;
    data_grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        pick_data = bus.data_req &&
                    (!bus.inst_req || !rr_last_q);
        if (!reset && (bus.inst_req || bus.data_req)) begin
          inst_grant = !pick_data;
          data_grant = pick_data;
          owner_d    = pick_data;
          rr_last_d  = pick_data;
          cnt_d      = '0;
          if (pick_data) begin
            addr_d  = bus.data_addr;
            we_d    = bus.data_we;
            wdata_d = bus.data_wdata;
            err_d   = (bus.data_addr[2:0] != 3'b000);
          end else begin
            addr_d  = bus.inst_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            err_d   = 1'b0;
          end
          state_d = err_d ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q) data_rdata_d = bus.mem_rdata;
            else         inst_rdata_d = bus.mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-access registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_last_q    <= 1'b0;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign in_busy = (state_q == BUSY);
  assign in_resp = (state_q == RESP);

  assign bus.inst_grant      = inst_grant;
  assign bus.data_grant      = data_grant;
  assign bus.inst_valid      = in_resp && !owner_q;
  assign bus.data_valid      = in_resp && owner_q;
  assign bus.data_misaligned = in_resp && owner_q && err_q;
  assign bus.inst_rdata      = inst_rdata_q;
  assign bus.data_rdata      = data_rdata_q;
  assign bus.mem_addr        = in_busy ? addr_q : '0;
  assign bus.mem_wdata       = in_busy ? wdata_q : '0;
  assign bus.mem_wr          = in_busy && we_q &&
                               (cnt_q == '0);
  assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter.
// Transaction-timeline reference model plus a memory model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset;
  logic load_mem;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(64),
    .MEM_LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  function automatic logic [63:0] pat(int i);
    if (i == 8) return 64'h0000_0000_0010_0093;
    return {32'hA5A5_0000 + 32'(i), 32'(i) * 32'h0101_0101};
  endfunction

  logic [63:0] dmem [64];
  logic [63:0] ref_mem [64];

  assign bus.mem_rdata = dmem[bus.mem_addr[8:3]];

  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) dmem[i] <= pat(i);
    end else if (bus.mem_wr) begin
      dmem[bus.mem_addr[8:3]] <= bus.mem_wdata;
    end
  end

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  // reference model: timeline of the access in flight
  int          free_cyc, mem_lo, mem_hi, resp_cyc, busy_lo;
  logic        rr_d, m_own, m_we, m_mis;
  logic [31:0] m_addr;
  logic [63:0] m_wdata, mi_rd, md_rd;
  logic        mg_i, mg_d;

  task automatic model_reset();
    free_cyc = 0;
    mem_lo   = -1;
    mem_hi   = -2;
    resp_cyc = -1;
    busy_lo  = 0;
    rr_d     = 1'b0;
    m_own    = 1'b0;
    m_we     = 1'b0;
    m_mis    = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    mi_rd    = '0;
    md_rd    = '0;
  endtask

  task automatic model_check();
    logic        ei, ed, evi, evd, emis, ewr, ebusy, pd;
    logic [31:0] ea;
    logic [63:0] ewd;
    ei = 0; ed = 0; evi = 0; evd = 0; emis = 0;
    ewr = 0; ebusy = 0; ea = '0; ewd = '0;
    if (reset) begin
      model_reset();
    end else begin
      if (cyc >= mem_lo && cyc <= mem_hi) begin
        ea  = m_addr;
        ewd = m_wdata;
        ewr = (cyc == mem_lo) && m_we;
        if (ewr) ref_mem[m_addr[8:3]] = m_wdata;
      end
      ebusy = (cyc >= busy_lo) && (cyc <= resp_cyc);
      if (cyc == resp_cyc) begin
        if (!m_own) begin
          evi   = 1;
          mi_rd = ref_mem[m_addr[8:3]];
        end else begin
          evd  = 1;
          emis = m_mis;
          if (!m_mis && !m_we) md_rd = ref_mem[m_addr[8:3]];
        end
      end
      if (cyc >= free_cyc &&
          (bus.inst_req || bus.data_req)) begin
        pd      = bus.data_req && (!bus.inst_req || !rr_d);
        ei      = !pd;
        ed      = pd;
        rr_d    = pd;
        m_own   = pd;
        m_addr  = pd ? bus.data_addr : bus.inst_addr;
        m_we    = pd && bus.data_we;
        m_wdata = pd ? bus.data_wdata : 64'd0;
        m_mis   = pd && (bus.data_addr[2:0] != 3'b000);
        busy_lo = cyc + 1;
        if (m_mis) begin
          mem_lo   = -1;
          mem_hi   = -2;
          resp_cyc = cyc + 1;
        end else begin
          mem_lo   = cyc + 1;
          mem_hi   = cyc + LAT;
          resp_cyc = cyc + LAT + 1;
        end
        free_cyc = resp_cyc + 1;
      end
    end
    mg_i = ei;
    mg_d = ed;
    chk("inst_grant", 64'(bus.inst_grant), 64'(ei));
    chk("data_grant", 64'(bus.data_grant), 64'(ed));
    chk("inst_valid", 64'(bus.inst_valid), 64'(evi));
    chk("data_valid", 64'(bus.data_valid), 64'(evd));
    chk("misaligned", 64'(bus.data_misaligned), 64'(emis));
    chk("mem_wr", 64'(bus.mem_wr), 64'(ewr));
    chk("mem_addr", 64'(bus.mem_addr), 64'(ea));
    chk("mem_wdata", bus.mem_wdata, ewd);
    chk("busy", 64'(bus.busy), 64'(ebusy));
    chk("inst_rdata", bus.inst_rdata, mi_rd);
    chk("data_rdata", bus.data_rdata, md_rd);
  endtask

  task automatic step();
    @(negedge clock);
    model_check();
    cyc++;
    @(posedge clock);
    #1;
    if (mg_i) bus.inst_req = 1'b0;
    if (mg_d) bus.data_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus.inst_req || bus.data_req ||
            cyc < free_cyc) && n < 60) begin
      step();
      n++;
    end
    chk("drain_budget", 64'(n < 60), 64'd1);
  endtask

  task automatic req_inst(logic [31:0] a);
    bus.inst_req  = 1'b1;
    bus.inst_addr = a;
  endtask

  task automatic req_data(logic we, logic [31:0] a,
                          logic [63:0] wd);
    bus.data_req   = 1'b1;
    bus.data_we    = we;
    bus.data_addr  = a;
    bus.data_wdata = wd;
  endtask

  initial begin
    logic [5:0]  idx;
    logic [2:0]  off;
    reset          = 1'b1;
    load_mem       = 1'b1;
    bus.inst_req   = 1'b0;
    bus.inst_addr  = '0;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    model_reset();

    repeat (3) step();

    req_inst(32'h40);
    req_data(1'b1, 32'h100, 64'hDEAD_BEEF);
    reset    = 1'b0;
    load_mem = 1'b0;
    drain();
    chk("fetch_0x40", bus.inst_rdata, 64'h10_0093);
    chk("store_keeps_rdata", bus.data_rdata, 64'd0);

    req_data(1'b0, 32'h100, 64'd0);
    drain();
    chk("load_0x100", bus.data_rdata, 64'hDEAD_BEEF);

    req_data(1'b0, 32'h103, 64'd0);
    drain();
    chk("misaligned_rdata", bus.data_rdata, 64'hDEAD_BEEF);

    for (int k = 0; k < 400; k++) begin
      if (!bus.inst_req && $urandom_range(0, 2) == 0) begin
        idx = 6'($urandom_range(0, 63));
        req_inst({23'd0, idx, 3'd0});
      end
      if (!bus.data_req && $urandom_range(0, 2) == 0) begin
        idx = 6'($urandom_range(0, 63));
        off = ($urandom_range(0, 5) == 0) ?
              3'($urandom_range(1, 7)) : 3'd0;
        req_data(1'($urandom_range(0, 1)),
                 {23'd0, idx, off},
                 {$urandom, $urandom});
      end
      step();
    end
    drain();

    req_data(1'b1, 32'h80, 64'h1111_2222_3333_4444);
    step();
    chk("pre_rst_mem_wr", 64'(bus.mem_wr), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    step();
    reset = 1'b0;
    req_inst(32'h80);
    drain();
    chk("post_rst_fetch", bus.inst_rdata, pat(16));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
